// File: rtl/data_bus_if_pkg.sv
// Shared types and constants for the data-side bus master.
package data_bus_if_pkg;

  localparam int unsigned REG_BUS = 32;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  // Transaction state: idle, waiting for ack, or holding read data while
  // another pipeline stage keeps the pipe stalled.
  typedef enum logic [1:0] {
    BUS_IDLE       = 2'd0,
    BUS_BUSY       = 2'd1,
    BUS_WAIT_STALL = 2'd2
  } bus_state_e;

  // Request fields driven onto the bus for the whole transaction.
  typedef struct packed {
    logic               we;
    logic [3:0]         sel;
    logic [REG_BUS-1:0] addr;
    logic [REG_BUS-1:0] data;
  } bus_req_t;

  localparam bus_req_t REQ_NONE = '0;

endpackage

// File: rtl/data_bus_if.sv
// Data-side bus master: single-outstanding strobe/ack transaction for the
// MEM stage, with pipeline stall request, flush abort and ack timeout.
module data_bus_if
  import data_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_ce_i,
  input  logic               cpu_we_i,
  input  logic [3:0]         cpu_sel_i,
  input  logic [REG_BUS-1:0] cpu_addr_i,
  input  logic [REG_BUS-1:0] cpu_data_i,
  input  logic [5:0]         stall_i,
  input  logic               flush_i,
  output logic [REG_BUS-1:0] cpu_data_o,
  output logic               stallreq_o,
  output logic               bus_err_o,
  output logic               bus_cyc_o,
  output logic               bus_stb_o,
  output logic               bus_we_o,
  output logic [3:0]         bus_sel_o,
  output logic [REG_BUS-1:0] bus_addr_o,
  output logic [REG_BUS-1:0] bus_data_o,
  input  logic               bus_ack_i,
  input  logic [REG_BUS-1:0] bus_data_i
);

  // The wait counter is 8 bits wide; the limit is compared at that width.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  bus_state_e         state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  bus_req_t           req_q, req_d;
  logic [REG_BUS-1:0] rd_buf_q, rd_buf_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               err_q, err_d;

  // Next-state, register updates and combinational stall/data outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    req_d      = req_q;
    rd_buf_d   = rd_buf_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    stallreq_o = 1'b0;
    cpu_data_o = ZERO_WORD;

    case (state_q)
      BUS_IDLE: begin
        // Stall from the very cycle the request appears: the result cannot
        // arrive before the bus has been strobed.
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          state_d = BUS_BUSY;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          req_d   = '{we: cpu_we_i, sel: cpu_sel_i, addr: cpu_addr_i, data: cpu_data_i};
          cnt_d   = '0;
        end
      end

      BUS_BUSY: begin
        if (flush_i) begin
          // Flush wins over a same-cycle ack; the read data is discarded.
          state_d = BUS_IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          req_d   = REQ_NONE;
        end else if (bus_ack_i) begin
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          req_d      = REQ_NONE;
          rd_buf_d   = req_q.we ? ZERO_WORD : bus_data_i;
          cpu_data_o = req_q.we ? ZERO_WORD : bus_data_i;
          // Keep the data available if another stage is still stalling.
          state_d    = (stall_i != '0) ? BUS_WAIT_STALL : BUS_IDLE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d = BUS_IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          req_d   = REQ_NONE;
          err_d   = 1'b1;
        end else begin
          cnt_d      = cnt_q + 8'd1;
          stallreq_o = 1'b1;
        end
      end

      BUS_WAIT_STALL: begin
        // No new request here: the stage that stalls us has not advanced.
        cpu_data_o = rd_buf_q;
        if (stall_i == '0 || flush_i) begin
          state_d = BUS_IDLE;
        end
      end

      default: begin
        state_d = BUS_IDLE;
      end
    endcase
  end

  // State and bus registers; reset drops cyc/stb without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BUS_IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      req_q    <= REQ_NONE;
      rd_buf_q <= ZERO_WORD;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge, independent of statement order.
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      req_q    <= req_d;
      rd_buf_q <= rd_buf_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus_cyc_o  = cyc_q;
  assign bus_stb_o  = stb_q;
  assign bus_we_o   = req_q.we;
  assign bus_sel_o  = req_q.sel;
  assign bus_addr_o = req_q.addr;
  assign bus_data_o = req_q.data;
  assign bus_err_o  = err_q;

endmodule

// File: tb/tb_data_bus_if.sv
// Self-checking bench for data_bus_if: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
module tb_data_bus_if;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        cpu_ce;
  logic        cpu_we;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] cpu_rdata;
  logic        stallreq;
  logic        bus_err;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_pass  = 0;
  int n_total = 0;

  // Model of the last value the read buffer should hold.
  logic [31:0] m_rd_buf = 32'h0;

  data_bus_if #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce),
    .cpu_we_i   (cpu_we),
    .cpu_sel_i  (cpu_sel),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_wdata),
    .stall_i    (stall),
    .flush_i    (flush),
    .cpu_data_o (cpu_rdata),
    .stallreq_o (stallreq),
    .bus_err_o  (bus_err),
    .bus_cyc_o  (bus_cyc),
    .bus_stb_o  (bus_stb),
    .bus_we_o   (bus_we),
    .bus_sel_o  (bus_sel),
    .bus_addr_o (bus_addr),
    .bus_data_o (bus_wdata),
    .bus_ack_i  (bus_ack),
    .bus_data_i (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction. ack_at is the BUSY cycle index (0 = first)
  // carrying the ack; negative or beyond TMO means no ack (timeout).
  // hold is the number of WAIT_STALL cycles after the ack (last one has
  // stall_i == 0). Expectations come from the protocol rules directly.
  task automatic do_txn(input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic [31:0] rdata,
                        input int hold, input string tag);
    bit          acked   = (ack_at >= 0) && (ack_at <= TMO);
    int          n_busy  = acked ? ack_at + 1 : TMO + 1;
    int          exp_stl = acked ? 1 + ack_at : 1 + TMO;
    logic [31:0] exp_rd  = we ? 32'h0 : rdata;
    int          stalls  = 0;
    logic [70:0] exp_bus;

    exp_bus = {2'b11, we, sel, addr, wdata};

    cpu_ce = 1'b1; cpu_we = we; cpu_sel = sel; cpu_addr = addr; cpu_wdata = wdata;
    stall = '0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    if (stallreq === 1'b1) stalls++;
    n_total++;
    if ({bus_cyc, bus_stb, cpu_rdata} !== 34'h0)
      $display("FAIL %s issue: cyc/stb/data=%h expected 0", tag, {bus_cyc, bus_stb, cpu_rdata});
    else n_pass++;
    next_cycle();

    for (int i = 0; i < n_busy; i++) begin
      // Scramble cpu inputs: the bus must keep the latched request.
      cpu_ce = 1'b0; cpu_we = 1'($urandom); cpu_sel = 4'($urandom);
      cpu_addr = $urandom; cpu_wdata = $urandom;
      bus_ack   = acked && (i == n_busy - 1);
      bus_rdata = bus_ack ? rdata : $urandom;
      stall     = bus_ack ? ((hold > 0) ? 6'b011111 : 6'd0) : 6'($urandom);
      @(negedge clk);
      if (stallreq === 1'b1) stalls++;
      n_total++;
      if ({bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata} !== exp_bus)
        $display("FAIL %s busy%0d fields: got %h expected %h", tag, i,
                 {bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata}, exp_bus);
      else n_pass++;
      n_total++;
      if ({stallreq, cpu_rdata} !== {(i < n_busy - 1), (bus_ack ? exp_rd : 32'h0)})
        $display("FAIL %s busy%0d stallreq/data: got %b/%h expected %b/%h", tag, i,
                 stallreq, cpu_rdata, (i < n_busy - 1), (bus_ack ? exp_rd : 32'h0));
      else n_pass++;
      next_cycle();
    end
    bus_ack = 1'b0;
    if (acked) m_rd_buf = exp_rd;

    if (acked) begin
      for (int j = 0; j < hold; j++) begin
        // Request present while held: it must not be issued.
        cpu_ce = 1'b1; cpu_addr = $urandom;
        stall  = (j < hold - 1) ? 6'b011111 : 6'd0;
        @(negedge clk);
        n_total++;
        if ({bus_cyc, bus_stb, stallreq, cpu_rdata} !== {3'b000, exp_rd})
          $display("FAIL %s wait%0d: cyc/stb/stallreq/data=%b%b%b/%h expected 000/%h",
                   tag, j, bus_cyc, bus_stb, stallreq, cpu_rdata, exp_rd);
        else n_pass++;
        next_cycle();
      end
    end

    cpu_ce = 1'b0; stall = '0;
    @(negedge clk);
    n_total++;
    if ({bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata, stallreq, cpu_rdata} !== '0)
      $display("FAIL %s idle: bus/stallreq/data not cleared (cyc=%b stb=%b addr=%h data=%h)",
               tag, bus_cyc, bus_stb, bus_addr, cpu_rdata);
    else n_pass++;
    n_total++;
    if (bus_err !== !acked)
      $display("FAIL %s err pulse: got %b expected %b", tag, bus_err, !acked);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++;
    if (bus_err !== 1'b0)
      $display("FAIL %s err width: got %b expected 0", tag, bus_err);
    else n_pass++;
    n_total++;
    if (stalls != exp_stl)
      $display("FAIL %s stall cycles: got %0d expected %0d", tag, stalls, exp_stl);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_ce = 1'b0; cpu_we = 1'b0; cpu_sel = '0; cpu_addr = '0;
    cpu_wdata = '0; stall = '0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    #2;
    n_total++;
    if ({bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata, bus_err, stallreq, cpu_rdata} !== '0)
      $display("FAIL reset outputs: cyc=%b stb=%b err=%b stallreq=%b data=%h expected all 0",
               bus_cyc, bus_stb, bus_err, stallreq, cpu_rdata);
    else n_pass++;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_load_wait();
    do_txn(1'b0, 4'hF, 32'h0000_0040, 32'h0, 3, 32'h1234_5678, 0, "load_wait");
  endtask

  task automatic test_store_immediate();
    do_txn(1'b1, 4'b0011, 32'h0000_0100, 32'hAABB_CCDD, 0, 32'h5555_5555, 0, "store_imm");
  endtask

  task automatic test_wait_stall();
    do_txn(1'b0, 4'hF, 32'h0000_0200, 32'h0, 1, 32'hCAFE_F00D, 3, "wait_stall");
  endtask

  task automatic test_flush_ack();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_addr = 32'h300; cpu_wdata = '0;
    next_cycle();
    cpu_ce = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus_cyc, bus_stb, stallreq} !== 3'b111)
      $display("FAIL flush busy0: cyc/stb/stallreq=%b expected 111", {bus_cyc, bus_stb, stallreq});
    else n_pass++;
    next_cycle();
    flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; stall = 6'b000001;
    @(negedge clk);
    n_total++;
    if (stallreq !== 1'b0)
      $display("FAIL flush stallreq: got %b expected 0", stallreq);
    else n_pass++;
    next_cycle();
    flush = 1'b0; bus_ack = 1'b0; stall = '0;
    @(negedge clk);
    n_total++;
    if ({bus_cyc, bus_stb, bus_addr, stallreq, cpu_rdata, bus_err} !== '0)
      $display("FAIL flush drop: cyc=%b stb=%b addr=%h stallreq=%b data=%h err=%b expected 0",
               bus_cyc, bus_stb, bus_addr, stallreq, cpu_rdata, bus_err);
    else n_pass++;
    n_total++;
    if (dut.rd_buf_q !== m_rd_buf)
      $display("FAIL flush rd_buf: got %h expected %h", dut.rd_buf_q, m_rd_buf);
    else n_pass++;
    next_cycle();
    // A flushed request in IDLE is never issued.
    cpu_ce = 1'b1; flush = 1'b1;
    @(negedge clk);
    n_total++;
    if (stallreq !== 1'b0)
      $display("FAIL flush idle stallreq: got %b expected 0", stallreq);
    else n_pass++;
    next_cycle();
    cpu_ce = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus_cyc, bus_stb} !== 2'b00)
      $display("FAIL flush idle issue: cyc/stb=%b expected 00", {bus_cyc, bus_stb});
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 4'h1, 32'h0000_0400, 32'h0, -1, 32'h0, 0, "timeout");
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      do_txn(1'($urandom), 4'($urandom), $urandom, $urandom,
             int'($urandom_range(0, TMO + 2)), $urandom,
             int'($urandom_range(0, 3)), $sformatf("rand%0d", t));
    end
  endtask

  task automatic test_reset_midflight();
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_sel = 4'hF; cpu_addr = 32'h500; cpu_wdata = 32'h1111_2222;
    next_cycle();
    cpu_ce = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus_cyc, bus_stb} !== 2'b11)
      $display("FAIL midreset busy: cyc/stb=%b expected 11", {bus_cyc, bus_stb});
    else n_pass++;
    #1 rst = 1'b0;
    #1;
    n_total++;
    if ({bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata, bus_err, stallreq, cpu_rdata} !== '0)
      $display("FAIL midreset async: cyc=%b stb=%b addr=%h stallreq=%b expected all 0",
               bus_cyc, bus_stb, bus_addr, stallreq);
    else n_pass++;
    next_cycle();
    rst = 1'b1;
    m_rd_buf = 32'h0;
    @(negedge clk);
    n_total++;
    if ({bus_cyc, bus_stb, stallreq, dut.rd_buf_q} !== '0)
      $display("FAIL midreset idle: cyc=%b stb=%b stallreq=%b rd_buf=%h expected 0",
               bus_cyc, bus_stb, stallreq, dut.rd_buf_q);
    else n_pass++;
    next_cycle();
    // Bus still usable after reset.
    do_txn(1'b0, 4'hC, 32'h0000_0600, 32'h0, 2, 32'h0BAD_CAFE, 1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_load_wait();
    test_store_immediate();
    test_wait_stall();
    test_flush_ack();
    test_timeout();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
